// File: rtl/avalon_mm_master_if.sv
// Bundle of command, response and Avalon-MM fabric signals for avalon_mm_master.
// cmd_valid/cmd_ready: a command transfers on a rising edge where both are high; cmd_* are sampled only then.
interface avalon_mm_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [31:0]           cmd_writedata;
    logic [3:0]            cmd_byteenable;

    logic                  rsp_valid;
    logic [31:0]           rsp_readdata;
    logic                  rsp_error;

    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [31:0]           avm_writedata;
    logic [3:0]            avm_byteenable;
    logic                  avm_waitrequest;
    logic [31:0]           avm_readdata;
    logic                  avm_readdatavalid;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: one single-beat read or write at a time, with waitrequest,
// variable read latency and a saturating timeout that aborts transfers to dead slaves.
module avalon_mm_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                resetn,
    avalon_mm_master_if.master  bus,
    output logic [1:0]          dbg_state
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] count;
    logic        xfer_write;

    logic wr_done;
    logic rd_done;
    logic done;
    logic expired;

    always_comb begin
        wr_done = (state == ST_REQ) && xfer_write && !bus.avm_waitrequest;
        rd_done = !xfer_write && bus.avm_readdatavalid &&
                  (((state == ST_REQ) && !bus.avm_waitrequest) || (state == ST_RDWAIT));
        done    = wr_done || rd_done;
        expired = (count == LAST_COUNT);
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state              <= ST_IDLE;
            count              <= 16'd0;
            xfer_write         <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_writedata  <= 32'd0;
            bus.avm_byteenable <= 4'd0;
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_error      <= 1'b0;
            bus.rsp_readdata   <= 32'd0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.avm_address    <= bus.cmd_address;
                        bus.avm_writedata  <= bus.cmd_writedata;
                        bus.avm_byteenable <= bus.cmd_byteenable;
                        bus.avm_read       <= ~bus.cmd_write;
                        bus.avm_write      <= bus.cmd_write;
                        xfer_write         <= bus.cmd_write;
                        count              <= 16'd0;
                        state              <= ST_REQ;
                    end
                end
                ST_REQ, ST_RDWAIT: begin
                    if (count != 16'hFFFF) begin
                        count <= count + 16'd1;
                    end
                    // Completion takes priority over an expiry landing in the same cycle.
                    if (done) begin
                        bus.avm_read  <= 1'b0;
                        bus.avm_write <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        if (rd_done) begin
                            bus.rsp_readdata <= bus.avm_readdata;
                        end
                        state <= ST_RESP;
                    end else if (expired) begin
                        bus.avm_read  <= 1'b0;
                        bus.avm_write <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_error <= 1'b1;
                        if (!xfer_write) begin
                            bus.rsp_readdata <= 32'd0;
                        end
                        state <= ST_RESP;
                    end else if ((state == ST_REQ) && !bus.avm_waitrequest) begin
                        bus.avm_read <= 1'b0;
                        state        <= ST_RDWAIT;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/avalon_mm_master.md
# avalon_mm_master

Avalon-MM initiator that issues single 32-bit read or write transfers on the fabric on behalf of a simple valid/ready command port. It is the driving end of the memory-mapped slaves on our fabric, such as the 32-bit byte-enabled register peripheral. Used by custom logic that must reach peripherals without a Nios core. It handles `waitrequest` back-pressure and variable read latency via `readdatavalid`, with one transfer outstanding at a time. A programmable timeout prevents a dead slave from hanging the initiator.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of command and fabric address.
- `TIMEOUT_CYCLES`, 255, maximum cycles a transfer may spend in REQ+RDWAIT before abort; legal range 2..65535.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: single clock.
  - `resetn` in 1: asynchronous, active-low reset.
- Command port:
  - `cmd_valid` in 1: command present.
  - `cmd_ready` out 1: block can accept a command.
  - `cmd_write` in 1: 1 = write, 0 = read.
  - `cmd_address` in ADDR_WIDTH: byte address.
  - `cmd_writedata` in 32: write data.
  - `cmd_byteenable` in 4: byte lanes, used for both reads and writes.
- Response port:
  - `rsp_valid` out 1: one-cycle completion pulse.
  - `rsp_readdata` out 32: read result.
  - `rsp_error` out 1: timeout abort, valid with `rsp_valid`.
- Fabric port:
  - `avm_address` out ADDR_WIDTH, `avm_read` out 1, `avm_write` out 1, `avm_writedata` out 32, `avm_byteenable` out 4: fabric request signals.
  - `avm_waitrequest` in 1, `avm_readdata` in 32, `avm_readdatavalid` in 1: fabric response signals.

## Operation
- FSM states: IDLE, REQ, RDWAIT, RESP.
- IDLE:
  - `cmd_ready`=1 (decoded from state).
  - On `cmd_valid`, latch address, writedata, byteenable and direction into the `avm_*` registers, clear the timeout counter, and go to REQ.
- REQ:
  - Assert `avm_read` or `avm_write`; all `avm_*` outputs stay stable while `avm_waitrequest`=1.
  - Write accepted (`waitrequest`=0): go to RESP, `rsp_error`=0.
  - Read accepted with `readdatavalid`=1 in the same cycle: capture `avm_readdata` and go to RESP.
  - Read accepted otherwise: go to RDWAIT.
- RDWAIT:
  - `avm_read`=0.
  - On `avm_readdatavalid`, capture `avm_readdata` into `rsp_readdata` and go to RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, `cmd_ready`=0.
  - Next state is IDLE.
- Timeout:
  - The counter increments every cycle in REQ and RDWAIT; it is not cleared on the REQ→RDWAIT transition.
  - When the count reaches TIMEOUT_CYCLES-1 and no completion occurs that cycle, deassert `avm_read`/`avm_write` and go to RESP with `rsp_error`=1 and `rsp_readdata`=0.
  - A completion in the same cycle as expiry wins: `rsp_error`=0.
  - The counter is wide enough for 65535 and saturates rather than wrapping.
- `rsp_readdata` changes only on read completion or read timeout. Write responses leave it unchanged.
- `avm_readdatavalid` in IDLE, REQ-write or RESP is ignored. This covers late data after a timeout.
- Reset at any point returns to IDLE immediately and drops any in-flight transfer. No response is produced for it.
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_error`=0, `rsp_readdata`=0.
  - `avm_read`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `avm_byteenable`=0.

## Timing
- Command handshake on edge N → `avm_read`/`avm_write` high in cycle N+1.
- Zero-wait write: accepted in cycle N+1, `rsp_valid` in N+2, `cmd_ready` back in N+3.
- Each `waitrequest` cycle adds 1 cycle. A read with latency L after acceptance adds L cycles.
- Minimum command-to-command spacing is 3 cycles; throughput is one transfer per 3+wait+latency cycles.
- All outputs are registered except `cmd_ready`, which is decoded from state.
- `cmd_valid` is ignored outside IDLE. The command is not queued.

## Test plan
- Zero-wait write to 0x10, data 0xA5A5_1234, byteenable 0xF → `avm_write` high 1 cycle with those values; `rsp_valid` 2 cycles after handshake, `rsp_error`=0.
- Write with `waitrequest` held 5 cycles, byteenable 0x3 → `avm_*` outputs stable for all 6 REQ cycles; response at handshake+7.
- Read with `waitrequest`=0 and `readdatavalid` 3 cycles later, data 0xCAFE_F00D → `rsp_readdata`=0xCAFE_F00D, `rsp_error`=0; `avm_read` high exactly 1 cycle.
- Read with `readdatavalid` in the accept cycle, data 0x1 → response at handshake+2.
- TIMEOUT_CYCLES=8, slave holds `waitrequest`=1 → `avm_read` drops after 8 cycles; `rsp_error`=1, `rsp_readdata`=0. A later stray `readdatavalid` is ignored, and `cmd_ready` returns.
- `resetn` pulsed low while in RDWAIT → all outputs at reset values asynchronously, no `rsp_valid`. The next read completes normally.
